// File: rtl/lock_disp_pkg.sv
// Shared types and constants for the lock display controller.
// Holds the controller state enum, the active-low segment patterns
// ({dp,g,f,e,d,c,b,a}) and the decimal-point bit index.
package lock_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_ERR     = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_N     = 8'hAB;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_L     = 8'hC7;

  localparam int unsigned DP_BIT = 7;

endpackage

// File: rtl/lock_display_ctrl_seg_decode.sv
// Combinational BCD to active-low 7-segment decode.
// Ports: bcd_i  - BCD digit (values above 9 decode to blank)
//        seg_c_o - segment byte {dp,g,f,e,d,c,b,a}, dp off
module seg_decode
  import lock_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
      default: seg_c_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lock_display_ctrl.sv
// Digital lock sequencing controller for a 4-digit 7-segment display.
// Collects a 4-digit keypad code, compares it with CODE and shows
// entry / OPEn / Err / lockout countdown on the segment bytes.
// Ports: clk_100Hz, rst (async, active-high)
//        key_valid/key_val - digit key pulse and BCD value
//        key_clr, key_enter - discard / submit pulses
//        digit0..digit3 - registered active-low segment bytes (digit0 rightmost)
//        unlocked, lockout - registered status flags
module lock_display_ctrl
  import lock_disp_pkg::*;
#(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int unsigned BLINK_TICKS = 50,
  parameter int unsigned MSG_TICKS   = 200,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCKOUT_SEC = 30
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  input  logic       key_clr,
  input  logic       key_enter,
  output logic [7:0] digit0,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic [7:0] digit3,
  output logic       unlocked,
  output logic       lockout
);

  localparam int unsigned MSG_W   = $clog2(MSG_TICKS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned FAIL_W  = 3;
  localparam int unsigned PRE_W   = 7;
  localparam int unsigned CNT_W   = 3;

  localparam logic [3:0]        LOCK_TENS = 4'(LOCKOUT_SEC / 10);
  localparam logic [3:0]        LOCK_ONES = 4'(LOCKOUT_SEC % 10);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(99);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(4);

  state_e             state_q, state_d;
  logic [15:0]        entry_q, entry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               cur_on_q, cur_on_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [3:0][7:0]    dig_q, dig_d;
  logic               unl_q, unl_d;
  logic               lock_q, lock_d;

  logic               digit_ok_c;
  logic [3:0][3:0]    dec_in_c;
  logic [3:0][7:0]    dec_seg_c;

  assign digit_ok_c = key_valid && (key_val <= 4'd9);

  // State and datapath registers
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      entry_q  <= '0;
      count_q  <= '0;
      fail_q   <= '0;
      blink_q  <= '0;
      cur_on_q <= 1'b0;
      msg_q    <= '0;
      pre_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      dig_q    <= {4{SEG_DASH}};
      unl_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      fail_q   <= fail_d;
      blink_q  <= blink_d;
      cur_on_q <= cur_on_d;
      msg_q    <= msg_d;
      pre_q    <= pre_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      dig_q    <= dig_d;
      unl_q    <= unl_d;
      lock_q   <= lock_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    fail_d   = fail_q;
    blink_d  = blink_q;
    cur_on_d = cur_on_q;
    msg_d    = msg_q;
    pre_d    = pre_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (digit_ok_c) begin
          entry_d  = {12'h000, key_val};
          count_d  = CNT_W'(1);
          blink_d  = '0;
          cur_on_d = 1'b1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // clr beats enter beats a digit key in the same cycle
        if (key_clr) begin
          entry_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (key_enter) begin
          state_d = ST_CHECK;
        end else if (digit_ok_c && (count_q != CNT_FULL)) begin
          entry_d  = {entry_q[11:0], key_val};
          count_d  = count_q + CNT_W'(1);
          blink_d  = '0;
          cur_on_d = 1'b1;
        end else if (count_q != CNT_FULL) begin
          if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_d  = '0;
            cur_on_d = ~cur_on_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      ST_CHECK: begin
        entry_d = '0;
        count_d = '0;
        msg_d   = MSG_W'(MSG_TICKS - 1);
        if ((count_q == CNT_FULL) && (entry_q == CODE)) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else begin
          if (fail_q != FAIL_MAX) fail_d = fail_q + FAIL_W'(1);
          state_d = ST_ERR;
        end
      end
      ST_OPEN: begin
        if (msg_q == '0) state_d = ST_IDLE;
        else             msg_d   = msg_q - MSG_W'(1);
      end
      ST_ERR: begin
        if (msg_q == '0) begin
          if (fail_q == FAIL_MAX) begin
            pre_d   = '0;
            tens_d  = LOCK_TENS;
            ones_d  = LOCK_ONES;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          msg_d = msg_q - MSG_W'(1);
        end
      end
      ST_LOCKOUT: begin
        // One-second tick; 00 is held a full second before leaving
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
            fail_d  = '0;
            state_d = ST_IDLE;
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Low two decoders are shared between entry digits and countdown
  assign dec_in_c[0] = (state_d == ST_LOCKOUT) ? ones_d : entry_d[3:0];
  assign dec_in_c[1] = (state_d == ST_LOCKOUT) ? tens_d : entry_d[7:4];
  assign dec_in_c[2] = entry_d[11:8];
  assign dec_in_c[3] = entry_d[15:12];

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg_decode u_dec (
      .bcd_i   (dec_in_c[g]),
      .seg_c_o (dec_seg_c[g])
    );
  end

  // Display content for the next state; CHECK keeps the current bytes
  always_comb begin
    dig_d  = dig_q;
    unl_d  = (state_d == ST_OPEN);
    lock_d = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_IDLE: dig_d = {4{SEG_DASH}};
      ST_ENTRY: begin
        for (int i = 0; i < 4; i++) begin
          dig_d[i] = (CNT_W'(i) < count_d) ? dec_seg_c[i] : SEG_DASH;
        end
        if ((count_d != CNT_FULL) && cur_on_d) dig_d[0][DP_BIT] = 1'b0;
      end
      ST_CHECK:   dig_d = dig_q;
      ST_OPEN:    dig_d = {SEG_O, SEG_P, SEG_E, SEG_N};
      ST_ERR:     dig_d = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
      ST_LOCKOUT: dig_d = {SEG_L, SEG_DASH, dec_seg_c[1], dec_seg_c[0]};
      default:    dig_d = {4{SEG_DASH}};
    endcase
  end

  assign digit0   = dig_q[0];
  assign digit1   = dig_q[1];
  assign digit2   = dig_q[2];
  assign digit3   = dig_q[3];
  assign unlocked = unl_q;
  assign lockout  = lock_q;

endmodule

// File: tb/tb_lock_display_ctrl.sv
// Self-checking bench for lock_display_ctrl: a cycle-level behavioural
// model of the lock (digit list, elapsed-time counters) is compared with
// the DUT after every clock edge, plus literal display checks.
module tb_lock_display_ctrl;

  localparam int          BLINK = 50;
  localparam int          MSG   = 200;
  localparam int          MAXF  = 3;
  localparam int          LSEC  = 30;
  localparam logic [15:0] CODE  = 16'h1234;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_ERR = 4, M_LOCK = 5;

  logic       clk_100Hz = 1'b0;
  logic       rst;
  logic       key_valid, key_clr, key_enter;
  logic [3:0] key_val;
  logic [7:0] digit0, digit1, digit2, digit3;
  logic       unlocked, lockout;

  always #5 clk_100Hz = ~clk_100Hz;

  lock_display_ctrl #(
    .CODE(CODE), .BLINK_TICKS(BLINK), .MSG_TICKS(MSG),
    .MAX_FAILS(MAXF), .LOCKOUT_SEC(LSEC)
  ) dut (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .key_valid (key_valid),
    .key_val   (key_val),
    .key_clr   (key_clr),
    .key_enter (key_enter),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .unlocked  (unlocked),
    .lockout   (lockout)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Model: digits kept oldest-first, time tracked as elapsed cycles
  int         mode;
  int         dq[$];
  int         fail_m;
  int         since;
  int         el;
  logic [7:0] exp_d [4];
  logic       exp_unl, exp_lock;

  function automatic void model_reset();
    mode = M_IDLE;
    dq.delete();
    fail_m = 0;
    since = 0;
    el = 0;
    for (int i = 0; i < 4; i++) exp_d[i] = 8'hBF;
    exp_unl = 1'b0;
    exp_lock = 1'b0;
  endfunction

  function automatic void model_step();
    bit kv;
    int v;
    int code;
    int rem;
    int n;
    kv = key_valid && (key_val <= 4'd9);
    v = int'(key_val);
    case (mode)
      M_IDLE: if (kv) begin dq.delete(); dq.push_back(v); since = 0; mode = M_ENTRY; end
      M_ENTRY: begin
        if (key_clr) begin dq.delete(); mode = M_IDLE; end
        else if (key_enter) mode = M_CHECK;
        else if (kv && dq.size() < 4) begin dq.push_back(v); since = 0; end
        else since++;
      end
      M_CHECK: begin
        code = 0;
        foreach (dq[i]) code = code * 16 + dq[i];
        el = 0;
        if (dq.size() == 4 && code == int'(CODE)) begin fail_m = 0; mode = M_OPEN; end
        else begin if (fail_m < MAXF) fail_m++; mode = M_ERR; end
        dq.delete();
      end
      M_OPEN: begin el++; if (el == MSG) mode = M_IDLE; end
      M_ERR: begin
        el++;
        if (el == MSG) begin
          if (fail_m == MAXF) begin mode = M_LOCK; el = 0; end
          else mode = M_IDLE;
        end
      end
      M_LOCK: begin el++; if (el == (LSEC + 1) * 100) begin fail_m = 0; mode = M_IDLE; end end
      default: mode = M_IDLE;
    endcase
    n = dq.size();
    case (mode)
      M_IDLE: for (int i = 0; i < 4; i++) exp_d[i] = 8'hBF;
      M_ENTRY: begin
        for (int i = 0; i < 4; i++) exp_d[i] = (i < n) ? seg_tab[dq[n-1-i]] : 8'hBF;
        if (n < 4 && ((since / BLINK) % 2) == 0) exp_d[0] = exp_d[0] & 8'h7F;
      end
      M_OPEN: begin exp_d[3] = 8'hC0; exp_d[2] = 8'h8C; exp_d[1] = 8'h86; exp_d[0] = 8'hAB; end
      M_ERR:  begin exp_d[3] = 8'h86; exp_d[2] = 8'hAF; exp_d[1] = 8'hAF; exp_d[0] = 8'hFF; end
      M_LOCK: begin
        rem = LSEC - el / 100;
        exp_d[3] = 8'hC7; exp_d[2] = 8'hBF;
        exp_d[1] = seg_tab[rem / 10]; exp_d[0] = seg_tab[rem % 10];
      end
      default: ;
    endcase
    exp_unl = (mode == M_OPEN);
    exp_lock = (mode == M_LOCK);
  endfunction

  always @(posedge clk_100Hz or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle compare against the model
  always @(posedge clk_100Hz) begin
    #1;
    if (!rst) begin
      total++;
      if ({digit3, digit2, digit1, digit0, unlocked, lockout} !==
          {exp_d[3], exp_d[2], exp_d[1], exp_d[0], exp_unl, exp_lock}) begin
        bad++;
        $display("FAIL cycle t=%0t got=%h%h%h%h u=%b l=%b want=%h%h%h%h u=%b l=%b",
                 $time, digit3, digit2, digit1, digit0, unlocked, lockout,
                 exp_d[3], exp_d[2], exp_d[1], exp_d[0], exp_unl, exp_lock);
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_disp(input string nm, input logic [31:0] exp);
    check32(nm, {digit3, digit2, digit1, digit0}, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100Hz);
  endtask

  // One-cycle event pulse, sampled by the next rising edge
  task automatic ev(input bit kv, input logic [3:0] v, input bit clr, input bit ent);
    @(negedge clk_100Hz);
    key_valid = kv; key_val = v; key_clr = clr; key_enter = ent;
    @(negedge clk_100Hz);
    key_valid = 1'b0; key_val = 4'd0; key_clr = 1'b0; key_enter = 1'b0;
  endtask

  task automatic key(input logic [3:0] v);
    ev(1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) key(4'((c >> (4 * i)) & 16'hF));
  endtask

  initial begin
    key_valid = 1'b0; key_val = 4'd0; key_clr = 1'b0; key_enter = 1'b0;
    rst = 1'b1;
    #1;
    check_disp("reset_disp", 32'hBFBFBFBF);
    check32("reset_flags", {30'd0, unlocked, lockout}, 32'd0);
    #20;
    @(negedge clk_100Hz) rst = 1'b0;

    // Correct code unlocks for exactly MSG cycles
    enter_code(16'h1234);
    ev(1'b0, 4'd0, 1'b0, 1'b1);
    check_disp("check_hold", 32'hF9A4B099);
    tick(1);
    check_disp("open_disp", 32'hC08C86AB);
    check32("open_unl", {31'd0, unlocked}, 32'd1);
    tick(199);
    check32("open_last", {31'd0, unlocked}, 32'd1);
    tick(1);
    check32("open_done", {31'd0, unlocked}, 32'd0);
    check_disp("idle_after_open", 32'hBFBFBFBF);

    // Partial entry and cursor blink
    key(4'd5);
    key(4'd6);
    check_disp("entry56", 32'hBFBF9202);
    tick(49);
    check_disp("dp_still_on", 32'hBFBF9202);
    tick(1);
    check_disp("dp_off", 32'hBFBF9282);
    tick(50);
    check_disp("dp_on_again", 32'hBFBF9202);
    ev(1'b0, 4'd0, 1'b1, 1'b0);
    check_disp("clr_idle", 32'hBFBFBFBF);
    ev(1'b0, 4'd0, 1'b0, 1'b1);
    check_disp("enter_in_idle", 32'hBFBFBFBF);

    // Three wrong codes lead to lockout
    for (int r = 0; r < 3; r++) begin
      enter_code(16'h1235);
      ev(1'b0, 4'd0, 1'b0, 1'b1);
      tick(1);
      check_disp("err_disp", 32'h86AFAFFF);
      tick(200);
    end
    check32("lock_on", {31'd0, lockout}, 32'd1);
    check_disp("lock_30", 32'hC7BFB0C0);
    tick(100);
    check_disp("lock_29", 32'hC7BFA490);
    key(4'd1);
    tick(2997);
    check_disp("lock_00", 32'hC7BFC0C0);
    check32("lock_hold", {31'd0, lockout}, 32'd1);
    tick(1);
    check32("lock_done", {31'd0, lockout}, 32'd0);
    check_disp("idle_after_lock", 32'hBFBFBFBF);

    // Enter beats a digit key; clr beats enter
    enter_code(16'h1234);
    ev(1'b1, 4'd7, 1'b0, 1'b1);
    tick(1);
    check32("enter_beats_key", {31'd0, unlocked}, 32'd1);
    tick(200);
    key(4'd9);
    ev(1'b0, 4'd0, 1'b1, 1'b1);
    check_disp("clr_beats_enter", 32'hBFBFBFBF);
    tick(3);
    check_disp("no_err_after_clr", 32'hBFBFBFBF);

    // Out-of-range and fifth keys are ignored
    key(4'd1);
    key(4'hC);
    key(4'd2);
    key(4'd3);
    key(4'd4);
    key(4'd5);
    check_disp("fifth_ignored", 32'hF9A4B099);
    tick(60);
    check_disp("full_no_dp", 32'hF9A4B099);
    ev(1'b0, 4'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of OPEN
    enter_code(16'h1234);
    ev(1'b0, 4'd0, 1'b0, 1'b1);
    tick(1);
    tick(99);
    #1 rst = 1'b1;
    #1;
    check32("async_rst_unl", {31'd0, unlocked}, 32'd0);
    check_disp("async_rst_disp", 32'hBFBFBFBF);
    tick(2);
    rst = 1'b0;
    enter_code(16'h1234);
    ev(1'b0, 4'd0, 1'b0, 1'b1);
    tick(1);
    check32("unlock_after_rst", {31'd0, unlocked}, 32'd1);
    tick(200);
    check32("relock_after_rst", {31'd0, unlocked}, 32'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
